mem_alu_sequencer: RTL and testbench
====================================

Name: mem_alu_sequencer

Overview:
- Parametrised successor to the lab memory controller.
- On a start pulse, it bursts N_WORDS operands from an external synchronous SRAM into an internal register file.
- It then applies an ALU operation to each register pair (reg[2k], reg[2k+1]) and writes N_WORDS/2 results back to SRAM at a programmable destination base.
- Adds over the old controller: start/busy/done handshake, base addresses, fixed or auto-incrementing op mode, pipelined one-word-per-cycle transfers, and a debug read port.

Parameters:
- DATA_W, 8: data word width; 2 or more.
- ADDR_W, 5: SRAM address width.
- N_WORDS, 8: words loaded per run. Must be even and 2 or more; elaboration error otherwise.
- IDX_W, $clog2(N_WORDS): register index width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high; sampled on the clk rising edge.
- start  in  1  1-cycle request; honoured only in IDLE.
- src_base  in  ADDR_W  first SRAM read address; latched on start.
- dst_base  in  ADDR_W  first SRAM write address; latched on start.
- op_cfg  in  3  op code (fixed mode) or first op (increment mode); latched on start.
- op_mode  in  1  0 = fixed op for all pairs; 1 = op increments mod 8 after each pair. Latched on start.
- busy  out  1  high from the cycle after start is accepted through the DONE state.
- done  out  1  1-cycle pulse in the DONE state.
- mem_cs  out  1  SRAM chip select, active-high.
- mem_we  out  1  1 = write, 0 = read (valid only when mem_cs=1).
- mem_addr  out  ADDR_W  SRAM address.
- mem_wdata  out  DATA_W  SRAM write data.
- mem_rdata  in  DATA_W  SRAM read data; valid one cycle after a read request.
- dbg_idx  in  IDX_W  register file debug index.
- dbg_data  out  DATA_W  combinational reg[dbg_idx].

Behaviour:
- Reset values: busy=0, done=0, mem_cs=0, mem_we=0, mem_addr=0, mem_wdata=0. Register file cleared to 0; FSM goes to IDLE. Reset mid-run aborts immediately; no further SRAM access occurs.
- FSM states: IDLE -> LOAD -> DRAIN -> COMPUTE -> DONE -> IDLE.
- IDLE: outputs idle. start=1 latches the config and moves to LOAD. Counter i=0.
- LOAD (N_WORDS cycles): mem_cs=1, mem_we=0, mem_addr=src_base+i. i increments each cycle. From the second LOAD cycle onward, mem_rdata is written into reg[i-1]. On the last cycle go to DRAIN.
- DRAIN (1 cycle): mem_cs=0; mem_rdata is captured into reg[N_WORDS-1]. Counter k=0.
- COMPUTE (N_WORDS/2 cycles): mem_cs=1, mem_we=1, mem_addr=dst_base+k, mem_wdata=alu(op, reg[2k], reg[2k+1]).
  - After each write, k increments.
  - In increment mode, op becomes (op+1) mod 8 after each write.
  - On the last k, go to DONE.
- DONE (1 cycle): done=1, mem_cs=0; next state IDLE.
- Latency: busy lasts exactly N_WORDS + 1 + N_WORDS/2 + 1 cycles. With defaults that is 14 cycles.
- Address arithmetic is mod 2^ADDR_W; e.g. src_base=30 with 8 words reads 30, 31, 0 .. 5.
- Overlapping source/destination ranges are legal: all reads complete before the first write.
- start while busy is ignored; there is no queueing. start in the DONE cycle is also ignored.
- Register outputs: mem_* driven from registers, so no combinational path from mem_rdata to any mem_* output.
- ALU ops (a=reg[2k], b=reg[2k+1]); results are truncated to DATA_W, with carry/borrow discarded:
  - 0 ADD a+b
  - 1 SUB a-b (two's complement wrap)
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT a
  - 6 SHL a by 1
  - 7 SHR a by 1 (logical)
- Register file contents persist after DONE until the next LOAD overwrites them or reset clears them.

Decomposition:
- Package mem_seq_pkg:
  - op code localparams OP_ADD..OP_SHR (3-bit);
  - FSM state encoding S_IDLE, S_LOAD, S_DRAIN, S_COMPUTE, S_DONE (3-bit).
- Sub-module seq_alu: combinational; parameter DATA_W; ports op, a, b, y.
- Register file and FSM stay in mem_alu_sequencer.

Test Plan:
- Defaults; SRAM[0..7]=1,2,3,4,5,6,7,8; start with src=0, dst=16, op_cfg=0, op_mode=0 -> SRAM[16..19]=3,7,11,15; done pulses exactly 14 cycles after the start edge; busy=1 for those 14 cycles.
- Same data, op_cfg=0, op_mode=1 -> ops ADD, SUB, AND, OR -> SRAM[16..19]=3, 0xFF, 4, 15; dbg_idx=7 gives dbg_data=8.
- Wrap: src=30, dst=31, SRAM[30,31,0..5]=0xF0,0x20,0,0,0,0,0,0, op ADD fixed -> reads at 30, 31, 0..5; writes at 31, 0, 1, 2; SRAM[31]=0x10 (carry dropped).
- start pulsed again mid-COMPUTE with different src/dst/op -> ignored; results and timing are identical to the single-run case.
- reset asserted during LOAD cycle 3 -> next cycle busy=0, mem_cs=0, dbg_data=0 for all indices; no SRAM write occurs; a fresh start then completes normally.
- Per-op checks with a=0x81, b=0x03:
  - op_cfg=5, fixed -> 0x7E
  - op_cfg=6 -> 0x02
  - op_cfg=7 -> 0x40
  - op_cfg=1 -> 0x7E

Source files
------------

// File: rtl/mem_alu_sequencer_pkg.sv
// Shared op codes and FSM state encoding for the load/compute/store sequencer.
package mem_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_DRAIN   = 3'd2,
    S_COMPUTE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/mem_alu_sequencer_if.sv
// Synchronous SRAM port: master issues cs/we/addr/wdata, slave returns rdata one cycle after a read.
interface mem_alu_sequencer_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              mem_cs;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_cs, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_cs, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_alu_sequencer_alu.sv
// Two-operand ALU, results truncated to DATA_W.
// Latency: combinational. Backpressure: none.
module seq_alu
  import mem_seq_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD: y = a + b;
      OP_SUB: y = a - b;
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_NOT: y = ~a;
      OP_SHL: y = {a[DATA_W-2:0], 1'b0};
      OP_SHR: y = {1'b0, a[DATA_W-1:1]};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/mem_alu_sequencer.sv
// Loads N_WORDS from SRAM, applies the ALU to each register pair, writes N_WORDS/2 results back.
// Latency: N_WORDS + 1 + N_WORDS/2 + 1 busy cycles. Backpressure: none; start is ignored while busy.
module mem_alu_sequencer
  import mem_seq_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 5,
  parameter int N_WORDS = 8,
  parameter int IDX_W   = $clog2(N_WORDS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  src_base,
  input  logic [ADDR_W-1:0]  dst_base,
  input  logic [2:0]         op_cfg,
  input  logic               op_mode,
  output logic               busy,
  output logic               done,
  mem_alu_sequencer_if.master mem,
  input  logic [IDX_W-1:0]   dbg_idx,
  output logic [DATA_W-1:0]  dbg_data
);

  if (N_WORDS < 2 || (N_WORDS % 2) != 0) begin : g_bad_n_words
    $error("mem_alu_sequencer: N_WORDS must be even and at least 2");
  end
  if (DATA_W < 2) begin : g_bad_data_w
    $error("mem_alu_sequencer: DATA_W must be at least 2");
  end

  localparam logic [IDX_W-1:0] LAST_LOAD = IDX_W'(N_WORDS - 1);
  localparam logic [IDX_W-1:0] LAST_PAIR = IDX_W'(N_WORDS / 2 - 1);

  state_t            state_q, state_n;
  logic [IDX_W-1:0]  cnt_q, cnt_n, cnt_inc, cnt_dec;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [2:0]        op_q, op_n, op_step;
  logic              mode_q;

  logic              cs_q, cs_n, we_q, we_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic              busy_q, busy_n, done_q, done_n;

  logic [DATA_W-1:0] rf [N_WORDS];

  logic [IDX_W-1:0]  k_sel, idx_a, idx_b;
  logic [2:0]        alu_op;
  logic [DATA_W-1:0] alu_a, alu_b, alu_y;

  assign cnt_inc = cnt_q + IDX_W'(1);
  assign cnt_dec = cnt_q - IDX_W'(1);
  assign op_step = mode_q ? op_q + 3'd1 : op_q;

  // The write data for a pair is registered one cycle ahead of its write, so the
  // operands are those of the pair about to be written. In DRAIN the top register
  // is still in flight, so it is taken straight from the SRAM read port.
  always_comb begin
    k_sel  = (state_q == S_COMPUTE) ? cnt_inc : '0;
    alu_op = (state_q == S_COMPUTE) ? op_step : op_q;
    idx_a  = IDX_W'({k_sel, 1'b0});
    idx_b  = idx_a | IDX_W'(1);
    alu_a  = rf[idx_a];
    alu_b  = (state_q == S_DRAIN && idx_b == LAST_LOAD) ? mem.mem_rdata : rf[idx_b];
  end

  seq_alu #(.DATA_W(DATA_W)) u_alu (
    .op (alu_op),
    .a  (alu_a),
    .b  (alu_b),
    .y  (alu_y)
  );

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    op_n    = op_q;
    cs_n    = 1'b0;
    we_n    = 1'b0;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_n = S_LOAD;
          cnt_n   = '0;
          op_n    = op_cfg;
          cs_n    = 1'b1;
          addr_n  = src_base;
          busy_n  = 1'b1;
        end
      end
      S_LOAD: begin
        busy_n = 1'b1;
        if (cnt_q == LAST_LOAD) begin
          state_n = S_DRAIN;
        end else begin
          cnt_n  = cnt_inc;
          cs_n   = 1'b1;
          addr_n = src_q + ADDR_W'(cnt_inc);
        end
      end
      S_DRAIN: begin
        state_n = S_COMPUTE;
        cnt_n   = '0;
        busy_n  = 1'b1;
        cs_n    = 1'b1;
        we_n    = 1'b1;
        addr_n  = dst_q;
        wdata_n = alu_y;
      end
      S_COMPUTE: begin
        busy_n = 1'b1;
        if (cnt_q == LAST_PAIR) begin
          state_n = S_DONE;
          done_n  = 1'b1;
        end else begin
          cnt_n   = cnt_inc;
          op_n    = op_step;
          cs_n    = 1'b1;
          we_n    = 1'b1;
          addr_n  = dst_q + ADDR_W'(cnt_inc);
          wdata_n = alu_y;
        end
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      mode_q  <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      op_q    <= op_n;
      cs_q    <= cs_n;
      we_q    <= we_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      if (state_q == S_IDLE && start) begin
        src_q  <= src_base;
        dst_q  <= dst_base;
        mode_q <= op_mode;
      end
    end
  end

  // Read data trails its request by one cycle, hence the i-1 write index.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf <= '{default: '0};
    end else if (state_q == S_LOAD && cnt_q != '0) begin
      rf[cnt_dec] <= mem.mem_rdata;
    end else if (state_q == S_DRAIN) begin
      rf[LAST_LOAD] <= mem.mem_rdata;
    end
  end

  assign mem.mem_cs    = cs_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign dbg_data      = rf[dbg_idx];

endmodule

// File: tb/tb_mem_alu_sequencer.sv
// Bench for mem_alu_sequencer: SRAM model, write/read scoreboards, vector table and corner sequences.
module tb_mem_alu_sequencer;
  logic       clk;
  logic       reset;
  logic       start;
  logic [4:0] src_base, dst_base;
  logic [2:0] op_cfg;
  logic       op_mode;
  logic       busy, done;
  logic [2:0] dbg_idx;
  logic [7:0] dbg_data;

  int checks = 0;
  int errors = 0;

  mem_alu_sequencer_if #(.ADDR_W(5), .DATA_W(8)) mif ();

  mem_alu_sequencer #(.DATA_W(8), .ADDR_W(5), .N_WORDS(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .src_base (src_base),
    .dst_base (dst_base),
    .op_cfg   (op_cfg),
    .op_mode  (op_mode),
    .busy     (busy),
    .done     (done),
    .mem      (mif.master),
    .dbg_idx  (dbg_idx),
    .dbg_data (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model with a backdoor write port for preloading
  logic [7:0] sram [32];
  logic       bd_we;
  logic [4:0] bd_addr;
  logic [7:0] bd_data;

  always @(posedge clk) begin
    if (bd_we) sram[bd_addr] <= bd_data;
    else if (mif.mem_cs) begin
      if (mif.mem_we) sram[mif.mem_addr] <= mif.mem_wdata;
      else mif.mem_rdata <= sram[mif.mem_addr];
    end
  end

  logic [12:0] exp_wr_q [$];
  logic [4:0]  exp_rd_q [$];
  logic [12:0] wr_e;
  logic [4:0]  rd_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (mif.mem_cs) begin
      if (mif.mem_we) begin
        if (exp_wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr %0d data %0h, required no write", mif.mem_addr, mif.mem_wdata);
        end else begin
          wr_e = exp_wr_q.pop_front();
          check("wr_addr", 32'(mif.mem_addr), 32'(wr_e[12:8]));
          check("wr_data", 32'(mif.mem_wdata), 32'(wr_e[7:0]));
        end
      end else begin
        if (exp_rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read: addr %0d, required no read", mif.mem_addr);
        end else begin
          rd_e = exp_rd_q.pop_front();
          check("rd_addr", 32'(mif.mem_addr), 32'(rd_e));
        end
      end
    end
  end

  task automatic poke(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic preload(input logic [4:0] base, input logic [7:0][7:0] d);
    for (int i = 0; i < 8; i++) poke(base + 5'(i), d[i]);
  endtask

  // One full run: pushes expected traffic, checks handshake timing and results in SRAM
  task automatic run(input logic [4:0] src, input logic [4:0] dst, input logic [2:0] op,
                     input logic mode, input logic [3:0][7:0] res, input bit mid_start);
    int done_at;
    int busy_cnt;
    logic [4:0] a;
    for (int i = 0; i < 8; i++) exp_rd_q.push_back(src + 5'(i));
    for (int k = 0; k < 4; k++) begin
      a = dst + 5'(k);
      exp_wr_q.push_back({a, res[k]});
    end
    @(negedge clk);
    start = 1'b1; src_base = src; dst_base = dst; op_cfg = op; op_mode = mode;
    @(posedge clk);
    #1 start = 1'b0;
    done_at = 0;
    busy_cnt = 0;
    for (int n = 1; n <= 40 && done_at == 0; n++) begin
      @(negedge clk);
      if (mid_start && n == 10) begin
        start = 1'b1; src_base = 5'd9; dst_base = 5'd3; op_cfg = 3'd4; op_mode = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (busy) busy_cnt++;
      if (done) done_at = n;
    end
    start = 1'b0;
    check("done_cycle", 32'(done_at), 32'd14);
    check("busy_cycles", 32'(busy_cnt), 32'd14);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
    check("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
    check("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);
    for (int k = 0; k < 4; k++) begin
      a = dst + 5'(k);
      check("sram_result", 32'(sram[a]), 32'(res[k]));
    end
  endtask

  typedef struct packed {
    logic [7:0][7:0] d;
    logic [2:0]      op;
    logic            mode;
    logic [3:0][7:0] res;
  } vec_t;

  vec_t vecs [8];
  logic [7:0][7:0] d_seq, d_81, d_wrap;

  initial begin
    reset = 1'b1; start = 1'b0; src_base = '0; dst_base = '0;
    op_cfg = '0; op_mode = 1'b0; dbg_idx = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;

    d_seq  = {8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    d_81   = {4{8'h03, 8'h81}};
    d_wrap = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20, 8'hF0};
    vecs[0] = {d_seq, 3'd0, 1'b0, {8'h0F, 8'h0B, 8'h07, 8'h03}};
    vecs[1] = {d_seq, 3'd0, 1'b1, {8'h0F, 8'h04, 8'hFF, 8'h03}};
    vecs[2] = {d_81,  3'd5, 1'b0, {4{8'h7E}}};
    vecs[3] = {d_81,  3'd6, 1'b0, {4{8'h02}}};
    vecs[4] = {d_81,  3'd7, 1'b0, {4{8'h40}}};
    vecs[5] = {d_81,  3'd1, 1'b0, {4{8'h7E}}};
    vecs[6] = {d_81,  3'd6, 1'b1, {8'h7E, 8'h84, 8'h40, 8'h02}};
    vecs[7] = {d_81,  3'd2, 1'b1, {8'h7E, 8'h82, 8'h83, 8'h01}};

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cs", 32'(mif.mem_cs), 32'd0);
    check("rst_we", 32'(mif.mem_we), 32'd0);
    check("rst_addr", 32'(mif.mem_addr), 32'd0);
    check("rst_wdata", 32'(mif.mem_wdata), 32'd0);
    for (int i = 0; i < 8; i++) begin
      dbg_idx = 3'(i);
      #1 check("rst_rf", 32'(dbg_data), 32'd0);
    end
    reset = 1'b0;

    for (int v = 0; v < 8; v++) begin
      preload(5'd0, vecs[v].d);
      run(5'd0, 5'd16, vecs[v].op, vecs[v].mode, vecs[v].res, 1'b0);
      dbg_idx = 3'd7;
      #1 check("dbg_rf7", 32'(dbg_data), 32'(vecs[v].d[7]));
    end

    // start in mid-COMPUTE must be ignored
    preload(5'd0, d_seq);
    run(5'd0, 5'd16, 3'd0, 1'b0, vecs[0].res, 1'b1);

    // address wrap on both source and destination
    preload(5'd30, d_wrap);
    run(5'd30, 5'd31, 3'd0, 1'b0, {8'h00, 8'h00, 8'h00, 8'h10}, 1'b0);

    // reset during the third LOAD cycle
    preload(5'd0, d_seq);
    for (int i = 0; i < 3; i++) exp_rd_q.push_back(5'(i));
    @(negedge clk);
    start = 1'b1; src_base = 5'd0; dst_base = 5'd16; op_cfg = 3'd0; op_mode = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_cs", 32'(mif.mem_cs), 32'd0);
    check("abort_addr", 32'(mif.mem_addr), 32'd0);
    for (int i = 0; i < 8; i++) begin
      dbg_idx = 3'(i);
      #1 check("abort_rf", 32'(dbg_data), 32'd0);
    end
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_busy_later", 32'(busy), 32'd0);
    check("abort_rd_queue", 32'(exp_rd_q.size()), 32'd0);

    run(5'd0, 5'd16, 3'd0, 1'b1, vecs[1].res, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
